store_result_monitor: RTL and testbench
=======================================

Name: store_result_monitor

Overview:
- Sits directly downstream of the processor top level and consumes its data-memory store bus (MemWrite, DataAdr, WriteData).
- Counts and logs stores and buffers them in a small trace FIFO that the simulation environment or a debug port drains.
- Decides the run verdict: a store to the signature address with the expected value means PASS, any other value there means FAIL, and no signature store within the cycle budget means TIMEOUT.
- Replaces ad-hoc result checks with a reusable, synthesizable block.

Parameters:
- PASS_ADR, 32'd100: signature store address.
- PASS_DATA, 32'd25: value that signals success at PASS_ADR.
- TIMEOUT_CYCLES, 100: number of RUN cycles allowed before TIMEOUT. Must be 2 or more.
- DEPTH, 4: trace FIFO entries. Power of two, 2 or more.
- CNT_W, 16: store counter width.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high.
- MemWrite, input, 1: store strobe from top.
- DataAdr, input, 32: store address.
- WriteData, input, 32: store data.
- done, output, 1: verdict reached (pass, fail or timeout).
- pass, output, 1: signature matched.
- fail, output, 1: wrong data stored at PASS_ADR.
- timeout, output, 1: cycle budget exhausted.
- store_count, output, CNT_W: stores accepted, saturating.
- last_adr, output, 32: address of the most recent accepted store.
- last_data, output, 32: data of the most recent accepted store.
- trace_valid, output, 1: FIFO not empty.
- trace_ready, input, 1: consumer pops the head entry.
- trace_adr, output, 32: head entry address.
- trace_data, output, 32: head entry data.
- trace_overflow, output, 1: sticky flag, a store was dropped because the FIFO was full.

Behaviour:
- All outputs are registered. Inputs are sampled on the rising edge of clk. Effects are visible after that edge (1-cycle latency).
- Reset (synchronous, active-high, takes priority over everything):
  - State becomes RUN.
  - done, pass, fail, timeout, trace_overflow = 0.
  - store_count = 0, last_adr = 0, last_data = 0.
  - Cycle counter = 0.
  - FIFO empty, so trace_valid = 0; trace_adr and trace_data = 0.
- Asserting reset mid-run or in a terminal state clears everything the same way and restarts monitoring on the next cycle.
- States: RUN, PASS, FAIL, TIMEOUT. The three terminal states are sticky until reset.
- In RUN, on each edge:
  - Cycle counter increments.
  - If MemWrite=1, the store is accepted:
    - store_count increments; it saturates at all-ones.
    - last_adr and last_data are loaded.
    - A trace push is requested.
  - If the accepted store has DataAdr==PASS_ADR:
    - WriteData==PASS_DATA: go to PASS.
    - Any other value: go to FAIL.
  - Otherwise, if the cycle counter equals TIMEOUT_CYCLES-1: go to TIMEOUT.
  - A signature store in the same cycle as timeout expiry wins (PASS or FAIL, not TIMEOUT).
  - The terminal store itself is counted, latched and pushed.
- In terminal states:
  - MemWrite is ignored: no count, no latch, no push.
  - Cycle counter holds.
  - The FIFO can still be drained.
- Flag outputs: done = 1 in any terminal state; exactly one of pass, fail or timeout = 1 with it. All four are 0 in RUN.
- Stores to addresses other than PASS_ADR never change state. A bare address match without MemWrite is ignored.
- Trace FIFO:
  - trace_valid = !empty. trace_adr and trace_data show the head entry.
  - Pop occurs when trace_valid && trace_ready.
  - Push when not full: the entry is appended.
  - Push when full with no pop in the same cycle: the entry is dropped and trace_overflow is set (sticky until reset). The store still counts and still latches.
  - Push and pop in the same cycle while full: both happen, occupancy stays at DEPTH, no overflow.
  - Push and pop in the same cycle while empty: the entry is appended and trace_valid rises the next cycle. No bypass.
  - trace_ready while empty is ignored.
  - Read and write pointers wrap modulo DEPTH. Occupancy is tracked with a count register (or an extra pointer bit) so full and empty are distinguished.

Test Plan:
- Stores (0x60, 7), (0x64, 9), then (100, 25) on three consecutive cycles → pass=1 and done=1 after the third edge, store_count=3, last_adr=100, last_data=25, FIFO holds 3 entries in order, fail=0, timeout=0.
- Store (100, 24) → fail=1, done=1, pass=0. A following store (100, 25) is ignored: count stays 1, state stays FAIL.
- No stores for TIMEOUT_CYCLES cycles after reset release → timeout=1 exactly TIMEOUT_CYCLES edges after reset is deasserted, store_count=0. Variant: store (100, 25) on the final budget cycle → pass=1, timeout=0.
- With trace_ready=0, issue 6 stores to distinct addresses (none equal to 100) → occupancy 4, trace_overflow=1, store_count=6. Draining with trace_ready=1 returns the first 4 stores in order, then trace_valid=0.
- With the FIFO full and trace_ready=1, issue one store → head popped, new entry appended at the tail, trace_overflow stays 0.
- Reach PASS, then hold reset=1 for one edge → all outputs return to their reset values. A new (100, 25) store then yields pass=1 again with store_count=1.

Source files
------------

// File: rtl/store_result_monitor_if.sv
// Store bus between the processor top level and the store result monitor.
//   MemWrite  : store strobe
//   DataAdr   : store address
//   WriteData : store data
// master: the processor side driving the bus; slave: the monitor.
interface store_result_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/store_result_monitor.sv
// Store result monitor: counts and latches processor stores, buffers them in
// a small trace FIFO, and decides the run verdict (pass / fail / timeout).
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   bus (slave)     : store bus MemWrite / DataAdr / WriteData
//   done            : verdict reached
//   pass/fail/timeout : one-hot verdict, valid while done
//   store_count     : accepted stores, saturating
//   last_adr/last_data : most recent accepted store
//   trace_valid/trace_ready/trace_adr/trace_data : trace FIFO head and pop
//   trace_overflow  : sticky, a store was dropped on a full FIFO
module store_result_monitor #(
  parameter logic [31:0] PASS_ADR       = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  store_result_monitor_if.slave bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CNT_W-1:0]      store_count,
  output logic [31:0]           last_adr,
  output logic [31:0]           last_data,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_adr,
  output logic [31:0]           trace_data,
  output logic                  trace_overflow
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = AW + 1;
  localparam int unsigned CYC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t             state;
  logic [CYC_W-1:0]   cyc;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic [31:0]        mem_adr  [DEPTH];
  logic [31:0]        mem_data [DEPTH];

  logic               accept;
  logic               pop;
  logic               full;
  logic               do_push;
  logic               drop;
  logic               sig_hit;
  logic               expire;
  logic [AW-1:0]      rd_next;
  logic [OCC_W-1:0]   occ_next;
  logic [OCC_W-1:0]   occ_after_pop;
  logic [31:0]        head_adr_next;
  logic [31:0]        head_data_next;

  // Per-cycle decisions: store acceptance, FIFO movement and next head entry.
  always_comb begin
    accept         = 1'b0;
    pop            = 1'b0;
    full           = 1'b0;
    do_push        = 1'b0;
    drop           = 1'b0;
    sig_hit        = 1'b0;
    expire         = 1'b0;
    rd_next        = rd_ptr;
    occ_next       = occ;
    occ_after_pop  = occ;
    head_adr_next  = trace_adr;
    head_data_next = trace_data;

    accept  = (state == S_RUN) && bus.MemWrite;
    pop     = trace_valid && trace_ready;
    full    = (occ == OCC_W'(DEPTH));
    // A full FIFO still takes the push when the head leaves in the same cycle.
    do_push = accept && (!full || pop);
    drop    = accept && full && !pop;
    sig_hit = accept && (bus.DataAdr == PASS_ADR);
    expire  = (cyc == CYC_W'(TIMEOUT_CYCLES - 1));

    rd_next       = pop ? rd_ptr + AW'(1) : rd_ptr;
    occ_after_pop = occ - OCC_W'(pop);
    occ_next      = occ_after_pop + OCC_W'(do_push);

    // The head is registered; when the FIFO is (or becomes) empty before the
    // push lands, the pushed entry itself becomes the new head.
    if (do_push && (occ_after_pop == '0)) begin
      head_adr_next  = bus.DataAdr;
      head_data_next = bus.WriteData;
    end else if (occ_after_pop != '0) begin
      head_adr_next  = mem_adr[rd_next];
      head_data_next = mem_data[rd_next];
    end
  end

  // Trace storage; contents are don't-care until written so no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_adr[wr_ptr]  <= bus.DataAdr;
      mem_data[wr_ptr] <= bus.WriteData;
    end
  end

  // Verdict FSM, store bookkeeping and FIFO control.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_RUN;
      cyc            <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
      store_count    <= '0;
      last_adr       <= '0;
      last_data      <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occ            <= '0;
      trace_valid    <= 1'b0;
      trace_adr      <= '0;
      trace_data     <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (accept) begin
        if (store_count != '1) begin
          store_count <= store_count + CNT_W'(1);
        end
        last_adr  <= bus.DataAdr;
        last_data <= bus.WriteData;
      end

      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr      <= rd_next;
      occ         <= occ_next;
      trace_valid <= (occ_next != '0);
      trace_adr   <= head_adr_next;
      trace_data  <= head_data_next;
      if (drop) begin
        trace_overflow <= 1'b1;
      end

      case (state)
        S_RUN: begin
          // Signature store outranks a simultaneous budget expiry.
          if (sig_hit) begin
            done <= 1'b1;
            if (bus.WriteData == PASS_DATA) begin
              state <= S_PASS;
              pass  <= 1'b1;
            end else begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end
          end else if (expire) begin
            state   <= S_TIMEOUT;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_result_monitor.sv
// Self-checking bench for store_result_monitor: a driver applies directed and
// random stores, a reference model predicts each cycle's outputs into a queue,
// and a monitor compares the DUT against the queue one cycle later.
module tb_store_result_monitor;

  localparam int unsigned T     = 100;
  localparam int unsigned D     = 4;
  localparam int unsigned CW    = 16;
  localparam logic [31:0] P_ADR = 32'd100;
  localparam logic [31:0] P_DAT = 32'd25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          done, pass, fail, timeout;
  logic [CW-1:0] store_count;
  logic [31:0]   last_adr, last_data;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [31:0]   trace_adr, trace_data;
  logic          trace_overflow;

  store_result_monitor_if bus ();

  store_result_monitor #(
    .PASS_ADR(P_ADR), .PASS_DATA(P_DAT), .TIMEOUT_CYCLES(T), .DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .store_count(store_count), .last_adr(last_adr), .last_data(last_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_adr(trace_adr), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        done, pass, fail, timeout;
    logic [CW-1:0] cnt;
    logic [31:0] la, ld;
    logic        tv;
    logic [31:0] ta, td;
    logic        ovf;
    logic        head_zero;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    snap_id = 0;

  // Reference model state: verdict 0=run 1=pass 2=fail 3=timeout.
  int          m_verdict;
  int          m_cyc;
  int          m_cnt;
  logic [31:0] m_la, m_ld;
  logic [63:0] m_fifo[$];
  logic        m_ovf;
  logic        m_reset_seen;

  task automatic model_step(input bit rst, input bit mw, input logic [31:0] adr,
                            input logic [31:0] data, input bit rdy);
    bit do_pop, accept, was_full;
    if (rst) begin
      m_verdict = 0; m_cyc = 0; m_cnt = 0; m_la = 0; m_ld = 0;
      m_fifo.delete(); m_ovf = 1'b0; m_reset_seen = 1'b1;
      return;
    end
    m_reset_seen = 1'b0;
    do_pop   = (m_fifo.size() > 0) && rdy;
    was_full = (m_fifo.size() == D);
    accept   = (m_verdict == 0) && mw;
    if (m_verdict == 0) begin
      if (accept) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_la = adr; m_ld = data;
      end
      if (accept && adr == P_ADR) m_verdict = (data == P_DAT) ? 1 : 2;
      else if (m_cyc == T - 1) m_verdict = 3;
      else m_cyc++;
    end
    if (do_pop) void'(m_fifo.pop_front());
    if (accept) begin
      if (was_full && !do_pop) m_ovf = 1'b1;
      else m_fifo.push_back({adr, data});
    end
  endtask

  task automatic cycle(input bit rst, input bit mw, input logic [31:0] adr,
                       input logic [31:0] data, input bit rdy);
    snap_t s;
    @(negedge clk);
    reset = rst; bus.MemWrite = mw; bus.DataAdr = adr; bus.WriteData = data;
    trace_ready = rdy;
    model_step(rst, mw, adr, data, rdy);
    s.id = snap_id++;
    s.done = (m_verdict != 0); s.pass = (m_verdict == 1);
    s.fail = (m_verdict == 2); s.timeout = (m_verdict == 3);
    s.cnt = CW'(m_cnt); s.la = m_la; s.ld = m_ld;
    s.tv = (m_fifo.size() > 0);
    s.ta = s.tv ? m_fifo[0][63:32] : 32'd0;
    s.td = s.tv ? m_fifo[0][31:0] : 32'd0;
    s.ovf = m_ovf; s.head_zero = m_reset_seen;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data, input bit rdy);
    cycle(1'b0, 1'b1, adr, data, rdy);
  endtask

  // Monitor: compare DUT outputs to the oldest prediction after each edge.
  always @(posedge clk) begin
    snap_t s;
    bit    bad;
    #1;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      bad = 1'b0;
      if (done !== s.done || pass !== s.pass || fail !== s.fail || timeout !== s.timeout) bad = 1'b1;
      if (store_count !== s.cnt || last_adr !== s.la || last_data !== s.ld) bad = 1'b1;
      if (trace_valid !== s.tv || trace_overflow !== s.ovf) bad = 1'b1;
      if ((s.tv || s.head_zero) && (trace_adr !== s.ta || trace_data !== s.td)) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL cycle%0d: got d/p/f/t=%b%b%b%b cnt=%0d last=%h/%h tv=%b head=%h/%h ovf=%b ; expected d/p/f/t=%b%b%b%b cnt=%0d last=%h/%h tv=%b head=%h/%h ovf=%b",
                 s.id, done, pass, fail, timeout, store_count, last_adr, last_data,
                 trace_valid, trace_adr, trace_data, trace_overflow,
                 s.done, s.pass, s.fail, s.timeout, s.cnt, s.la, s.ld,
                 s.tv, s.ta, s.td, s.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] a, d;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;

    // Reset values
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, P_ADR, P_DAT, 1'b1);

    // Two ordinary stores then the signature, then drain the trace
    store(32'h60, 32'd7, 1'b0);
    store(32'h64, 32'd9, 1'b0);
    store(P_ADR, P_DAT, 1'b0);
    idle(4, 1'b1);

    // Wrong signature value, later correct one ignored
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    store(P_ADR, 32'd24, 1'b0);
    store(P_ADR, P_DAT, 1'b0);
    cycle(1'b0, 1'b0, P_ADR, P_DAT, 1'b0);

    // Pure timeout, then signature on the final budget cycle
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(T + 2, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(T - 1, 1'b1);
    store(P_ADR, P_DAT, 1'b0);
    idle(1, 1'b0);

    // Overflow: six stores with no drain, then drain
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) store(32'h200 + 32'(i * 4), 32'(i + 1), 1'b0);
    idle(6, 1'b1);

    // Full FIFO with simultaneous pop and push
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) store(32'h300 + 32'(i * 4), 32'(i + 10), 1'b0);
    store(32'h400, 32'd99, 1'b1);
    idle(6, 1'b1);

    // Push and pop while empty: no bypass
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    store(32'h500, 32'd5, 1'b1);
    idle(2, 1'b1);

    // Reset out of PASS and pass again
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    store(P_ADR, P_DAT, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    store(P_ADR, P_DAT, 1'b0);
    idle(1, 1'b0);

    // Random episodes, including occasional mid-run resets
    for (int e = 0; e < 8; e++) begin
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int c = 0; c < ((e == 7) ? T + 10 : 50); c++) begin
        r = $urandom_range(0, 19);
        a = (r == 0) ? P_ADR : 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
        r = $urandom_range(0, 3);
        d = (r == 0) ? P_DAT : ((r == 1) ? 32'd24 : $urandom);
        if ($urandom_range(0, 99) == 0) cycle(1'b1, 1'b0, a, d, 1'b0);
        else cycle(1'b0, ($urandom_range(0, (e == 7) ? 15 : 1) == 0), a, d,
                   ($urandom_range(0, 2) == 0));
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending predictions=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
